reg_file: RTL and testbench

- Parameterised 2^W x B-bit general-purpose register file.
- One synchronous write port and two independent asynchronous (combinational) read ports, A and B.
- Used as the operand store of a datapath: two source operands are read each cycle and one result is written back.
- All entries, including address 0, are ordinary writable storage.

---
 rtl/reg_file.sv | 58 +++++
 tb/tb_reg_file.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 2^W x B register file: one synchronous write port, two combinational read ports.
// Define REG_FILE_WRITE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file #(
  parameter int W = 5,
  parameter int B = 32
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr_A,
  input  logic [W-1:0] r_addr_B,
  output logic [B-1:0] r_data_A,
  output logic [B-1:0] r_data_B
);

  localparam int DEPTH = 1 << W;

  logic [B-1:0] mem_q [DEPTH];
  logic [B-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[w_addr] = w_data;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef REG_FILE_WRITE_BYPASS_EN
  logic hit_a;
  logic hit_b;

  // Forwarding is gated by reset so reads stay 0 while held in reset.
  always_comb begin
    hit_a = wr_en && n_reset && (r_addr_A == w_addr);
    hit_b = wr_en && n_reset && (r_addr_B == w_addr);
    r_data_A = hit_a ? w_data : mem_q[r_addr_A];
    r_data_B = hit_b ? w_data : mem_q[r_addr_B];
  end
`else
  always_comb begin
    r_data_A = mem_q[r_addr_A];
    r_data_B = mem_q[r_addr_B];
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected reads,
// a monitor pops and compares them against the DUT outputs.
module tb_reg_file;

  localparam int W = 5;
  localparam int B = 32;
  localparam int N = 1 << W;

  logic         clk = 0;
  logic         n_reset = 0;
  logic         wr_en = 0;
  logic [W-1:0] w_addr = '0;
  logic [B-1:0] w_data = '0;
  logic [W-1:0] r_addr_A = '0;
  logic [W-1:0] r_addr_B = '0;
  logic [B-1:0] r_data_A;
  logic [B-1:0] r_data_B;

  reg_file #(.W(W), .B(B)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .wr_en    (wr_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .r_addr_A (r_addr_A),
    .r_addr_B (r_addr_B),
    .r_data_A (r_data_A),
    .r_data_B (r_data_B)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [B-1:0] ea;
    logic [B-1:0] eb;
  } exp_t;

  exp_t         sb_q[$];
  event         sample;
  int           total = 0;
  int           bad = 0;
  logic [B-1:0] model [N];

  // Reference: an array updated on each enabled, non-reset write edge.
  always @(posedge clk) begin
    if (n_reset && wr_en) model[w_addr] = w_data;
  end

  function automatic logic [B-1:0] exp_rd(input logic [W-1:0] a);
    if (!n_reset) return '0;
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (wr_en && a == w_addr) return w_data;
`endif
    return model[a];
  endfunction

  task automatic push_chk(input string nm);
    exp_t e;
    e.name = nm;
    e.ea = exp_rd(r_addr_A);
    e.eb = exp_rd(r_addr_B);
    sb_q.push_back(e);
    ->sample;
    #1;
  endtask

  task automatic rd(input logic [W-1:0] a, input logic [W-1:0] b,
                    input string nm);
    @(negedge clk);
    r_addr_A = a;
    r_addr_B = b;
    #1;
    push_chk(nm);
  endtask

  task automatic wr(input logic [W-1:0] a, input logic [B-1:0] d);
    @(negedge clk);
    wr_en = 1;
    w_addr = a;
    w_data = d;
    @(posedge clk);
    #1;
    wr_en = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (r_data_A !== e.ea) begin
          bad++;
          $display("FAIL %s port A: got %h want %h", e.name, r_data_A, e.ea);
        end
        total++;
        if (r_data_B !== e.eb) begin
          bad++;
          $display("FAIL %s port B: got %h want %h", e.name, r_data_B, e.eb);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    clear_model();
    #2;
    r_addr_A = 5'd7;
    r_addr_B = 5'd30;
    wr_en = 1;
    w_addr = 5'd7;
    w_data = 32'hDEAD_BEEF;
    push_chk("in_reset");
    @(posedge clk);
    #1;
    push_chk("in_reset_wr_ignored");
    @(negedge clk);
    wr_en = 0;
    n_reset = 1;
    for (int i = 0; i < N; i++) rd(i[W-1:0], W'(N - 1 - i), "reset_sweep");

    wr(5'd0, 32'd10);
    wr(5'd1, 32'd15);
    for (int k = 0; k < 3; k++) rd(5'd0, 5'd1, "basic");

    wr(5'd20, 32'd100);
    wr(5'd21, 32'd200);
    rd(5'd20, 5'd21, "high");
    rd(5'd0, 5'd1, "low_kept");
    wr(5'd31, 32'hFFFF_FFFF);
    rd(5'd31, 5'd30, "addr31");

    @(negedge clk);
    wr_en = 0;
    w_addr = 5'd5;
    w_data = 32'h55;
    @(posedge clk);
    rd(5'd5, 5'd20, "wr_en_low");
    rd(5'd20, 5'd20, "same_addr");

    @(negedge clk);
    wr_en = 1;
    w_addr = 5'd1;
    w_data = 32'd77;
    r_addr_A = 5'd1;
    r_addr_B = 5'd0;
    #1;
    push_chk("rdw_pre");
    @(posedge clk);
    #1;
    wr_en = 0;
    push_chk("rdw_post");

    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      wr_en = 1'($urandom);
      w_addr = W'($urandom);
      w_data = $urandom;
      r_addr_A = ($urandom_range(0, 3) == 0) ? w_addr : W'($urandom);
      r_addr_B = ($urandom_range(0, 3) == 0) ? w_addr : W'($urandom);
      #1;
      push_chk("random");
    end
    @(negedge clk);
    wr_en = 0;
    rd(5'd20, 5'd31, "pre_async");

    @(negedge clk);
    #2;
    n_reset = 0;
    clear_model();
    #1;
    push_chk("async_rst");
    wr_en = 1;
    w_addr = 5'd3;
    w_data = 32'h1234;
    r_addr_A = 5'd3;
    r_addr_B = 5'd31;
    @(posedge clk);
    #1;
    push_chk("async_rst_wr");
    @(negedge clk);
    wr_en = 0;
    n_reset = 1;
    for (int i = 0; i < N; i++) rd(i[W-1:0], W'(N - 1 - i), "post_rst");
    wr(5'd3, 32'hA5A5_0001);
    rd(5'd3, 5'd4, "after_release");

    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
